// File: rtl/micro_sequencer.sv
// Microcode T-state sequencer: steps T0..T7, forms the microcode ROM address from the
// latched opcode and current T-state, and parks in HALTED at instruction boundaries.
//
// state  | meaning
// RUN    | sequencing T-states; side effects enabled unless stalled
// HALTED | parked at T0 after a boundary with halt_req high; waits for halt_req low
module micro_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        rt,
    input  logic        stall,
    input  logic        halt_req,
    input  logic [7:0]  opcode,
    output logic [10:0] uaddr,
    output logic [2:0]  tstate,
    output logic        ctl_en,
    output logic        insn_done,
    output logic        halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  tstate_q, tstate_d;
    logic [7:0]  opcode_q, opcode_d;
    logic        advance;
    logic        boundary;

    // T0/T1 are the fixed fetch cycles, so rt only counts from T2 onward; T7 is an implicit rt.
    assign advance  = (state_q == RUN) && !stall;
    assign boundary = advance && ((rt && (tstate_q >= 3'd2)) || (tstate_q == 3'd7));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            tstate_q <= 3'd0;
            opcode_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            tstate_q <= tstate_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tstate_d = tstate_q;
        opcode_d = opcode_q;
        case (state_q)
            RUN: begin
                if (advance) begin
                    if (boundary) begin
                        tstate_d = 3'd0;
                        if (halt_req) begin
                            state_d = HALTED;
                        end
                    end else begin
                        tstate_d = tstate_q + 3'd1;
                    end
                    if (tstate_q == 3'd1) begin
                        opcode_d = opcode;
                    end
                end
            end
            HALTED: begin
                tstate_d = 3'd0;
                if (!halt_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d  = RUN;
                tstate_d = 3'd0;
            end
        endcase
    end

    always_comb begin
        tstate    = tstate_q;
        uaddr     = (tstate_q < 3'd2) ? {8'h00, tstate_q} : {opcode_q, tstate_q};
        ctl_en    = (state_q == RUN) && !stall && !reset;
        insn_done = boundary && !reset;
        halted    = (state_q == HALTED);
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a vector table for the steady-state sequencing
// plus hand-written sequences for reset abort and halt entry/exit.
module tb_micro_sequencer;

    logic        clk;
    logic        reset;
    logic        rt;
    logic        stall;
    logic        halt_req;
    logic [7:0]  opcode;
    logic [10:0] uaddr;
    logic [2:0]  tstate;
    logic        ctl_en;
    logic        insn_done;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    micro_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .rt        (rt),
        .stall     (stall),
        .halt_req  (halt_req),
        .opcode    (opcode),
        .uaddr     (uaddr),
        .tstate    (tstate),
        .ctl_en    (ctl_en),
        .insn_done (insn_done),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rt;
        logic        st;
        logic        hr;
        logic [7:0]  op;
        logic [2:0]  t;
        logic [10:0] ua;
        logic        ce;
        logic        id;
        logic        hl;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle's inputs after the falling edge, then compare the outputs for that cycle.
    task automatic cyc(input string tag,
                       input logic rst_v, input logic rt_v, input logic st_v, input logic hr_v,
                       input logic [7:0] op_v,
                       input logic [2:0] et, input logic [10:0] eua,
                       input logic ece, input logic eid, input logic ehl);
        @(negedge clk);
        reset    = rst_v;
        rt       = rt_v;
        stall    = st_v;
        halt_req = hr_v;
        opcode   = op_v;
        #1;
        check({tag, ".tstate"},    int'(tstate),    int'(et));
        check({tag, ".uaddr"},     int'(uaddr),     int'(eua));
        check({tag, ".ctl_en"},    int'(ctl_en),    int'(ece));
        check({tag, ".insn_done"}, int'(insn_done), int'(eid));
        check({tag, ".halted"},    int'(halted),    int'(ehl));
    endtask

    task automatic add(input logic rst_v, input logic rt_v, input logic st_v, input logic hr_v,
                       input logic [7:0] op_v, input logic [2:0] et, input logic [10:0] eua,
                       input logic ece, input logic eid, input logic ehl);
        vec_t v;
        v.rst = rst_v; v.rt = rt_v; v.st = st_v; v.hr = hr_v; v.op = op_v;
        v.t = et; v.ua = eua; v.ce = ece; v.id = eid; v.hl = ehl;
        vecs.push_back(v);
    endtask

    initial begin
        reset    = 1'b1;
        rt       = 1'b0;
        stall    = 1'b0;
        halt_req = 1'b0;
        opcode   = 8'hA5;
        repeat (2) @(posedge clk);

        //   rst rt st hr op     | t  uaddr   ce id hl
        // reset held, then full 8-cycle instruction with opcode A5
        add(1, 0, 0, 0, 8'hA5, 0, 11'h000, 0, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 0, 11'h000, 1, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 1, 11'h001, 1, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 2, 11'h52A, 1, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 3, 11'h52B, 1, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 4, 11'h52C, 1, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 5, 11'h52D, 1, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 6, 11'h52E, 1, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 7, 11'h52F, 1, 1, 0);
        // rt held high: ignored in fetch, boundary at T2 -> 3-cycle instructions
        add(0, 1, 0, 0, 8'hA5, 0, 11'h000, 1, 0, 0);
        add(0, 1, 0, 0, 8'hA5, 1, 11'h001, 1, 0, 0);
        add(0, 1, 0, 0, 8'hA5, 2, 11'h52A, 1, 1, 0);
        add(0, 1, 0, 0, 8'hA5, 0, 11'h000, 1, 0, 0);
        add(0, 1, 0, 0, 8'hA5, 1, 11'h001, 1, 0, 0);
        add(0, 1, 0, 0, 8'hA5, 2, 11'h52A, 1, 1, 0);
        // stall for 3 cycles at T3 with rt high; stall beats rt
        add(0, 0, 0, 0, 8'hA5, 0, 11'h000, 1, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 1, 11'h001, 1, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 2, 11'h52A, 1, 0, 0);
        add(0, 1, 1, 0, 8'hA5, 3, 11'h52B, 0, 0, 0);
        add(0, 1, 1, 0, 8'hA5, 3, 11'h52B, 0, 0, 0);
        add(0, 1, 1, 0, 8'hA5, 3, 11'h52B, 0, 0, 0);
        add(0, 1, 0, 0, 8'hA5, 3, 11'h52B, 1, 1, 0);
        // opcode 12 latched at T1; change to 34 in T5 must not reach uaddr until next T1
        add(0, 0, 0, 0, 8'h12, 0, 11'h000, 1, 0, 0);
        add(0, 0, 0, 0, 8'h12, 1, 11'h001, 1, 0, 0);
        add(0, 0, 0, 0, 8'h12, 2, 11'h092, 1, 0, 0);
        add(0, 0, 0, 0, 8'h12, 3, 11'h093, 1, 0, 0);
        add(0, 0, 0, 0, 8'h12, 4, 11'h094, 1, 0, 0);
        add(0, 0, 0, 0, 8'h34, 5, 11'h095, 1, 0, 0);
        add(0, 0, 0, 0, 8'h34, 6, 11'h096, 1, 0, 0);
        add(0, 0, 0, 0, 8'h34, 7, 11'h097, 1, 1, 0);
        add(0, 0, 0, 0, 8'h34, 0, 11'h000, 1, 0, 0);
        add(0, 0, 0, 0, 8'h34, 1, 11'h001, 1, 0, 0);
        add(0, 0, 0, 0, 8'h34, 2, 11'h1A2, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].rt, vecs[i].st, vecs[i].hr,
                vecs[i].op, vecs[i].t, vecs[i].ua, vecs[i].ce, vecs[i].id, vecs[i].hl);
        end

        // reset at T6 while stalled: aborts with no insn_done
        cyc("rst_t3",   0, 0, 0, 0, 8'h34, 3, 11'h1A3, 1, 0, 0);
        cyc("rst_t4",   0, 0, 0, 0, 8'h34, 4, 11'h1A4, 1, 0, 0);
        cyc("rst_t5",   0, 0, 0, 0, 8'h34, 5, 11'h1A5, 1, 0, 0);
        cyc("rst_t6",   1, 0, 1, 0, 8'h34, 6, 11'h1A6, 0, 0, 0);
        cyc("rst_post", 0, 0, 0, 0, 8'h34, 0, 11'h000, 1, 0, 0);

        // halt_req pulse outside a boundary has no effect
        cyc("hp_t1",    0, 0, 0, 0, 8'h12, 1, 11'h001, 1, 0, 0);
        cyc("hp_t2",    0, 0, 0, 1, 8'h12, 2, 11'h092, 1, 0, 0);
        cyc("hp_t3",    0, 1, 0, 0, 8'h12, 3, 11'h093, 1, 1, 0);
        cyc("hp_t0",    0, 0, 0, 0, 8'h12, 0, 11'h000, 1, 0, 0);

        // halt_req at T4, held through the rt boundary at T5
        cyc("h_t1",     0, 0, 0, 0, 8'h12, 1, 11'h001, 1, 0, 0);
        cyc("h_t2",     0, 0, 0, 0, 8'h12, 2, 11'h092, 1, 0, 0);
        cyc("h_t3",     0, 0, 0, 0, 8'h12, 3, 11'h093, 1, 0, 0);
        cyc("h_t4",     0, 0, 0, 1, 8'h12, 4, 11'h094, 1, 0, 0);
        cyc("h_t5",     0, 1, 0, 1, 8'h12, 5, 11'h095, 1, 1, 0);
        cyc("h_park1",  0, 1, 1, 1, 8'h12, 0, 11'h000, 0, 0, 1);
        cyc("h_park2",  0, 1, 0, 1, 8'h12, 0, 11'h000, 0, 0, 1);
        cyc("h_rel",    0, 1, 1, 0, 8'h12, 0, 11'h000, 0, 0, 1);
        cyc("h_run0",   0, 0, 0, 0, 8'h12, 0, 11'h000, 1, 0, 0);
        cyc("h_run1",   0, 0, 0, 0, 8'h12, 1, 11'h001, 1, 0, 0);
        cyc("h_run2",   0, 1, 0, 1, 8'h12, 2, 11'h092, 1, 1, 0);

        // reset while HALTED returns to RUN at T0
        cyc("rh_halt",  1, 0, 0, 1, 8'h12, 0, 11'h000, 0, 0, 1);
        cyc("rh_post",  0, 0, 0, 1, 8'h12, 0, 11'h000, 1, 0, 0);
        cyc("rh_t1",    0, 0, 0, 0, 8'h12, 1, 11'h001, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
